// File: rtl/alu_mul_sequencer.sv
// ============================================================================
// Module   : alu_mul_sequencer
// Brief    : Shift-add RV64 MUL sequencer that borrows the shared ALU for adds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_sequencer #(
    parameter int          WIDTH    = 64,
    parameter int          CNT_W    = 7,
    parameter logic [3:0]  ADD_CODE = 4'b0010
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic [3:0]       pipe_ctrl,
    input  logic [WIDTH-1:0] pipe_a,
    input  logic [WIDTH-1:0] pipe_b,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             w_accept;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_mplier_shift;
    logic             w_last;

    assign w_accept       = start && !flush;
    // The ALU sum is only meaningful while RUN owns the ALU inputs.
    assign w_acc_next     = mplier_q[0] ? alu_y : acc_q;
    assign w_mplier_shift = mplier_q >> 1;
    assign w_last         = (w_mplier_shift == '0) || (count_q == c_LAST_CNT);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= c_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    state_d = (op_b != '0) ? c_RUN : c_DONE;
                end
            end
            c_RUN: begin
                if (flush) begin
                    state_d = c_IDLE;
                end else if (w_last) begin
                    state_d = c_DONE;
                end
            end
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        result_d = result_q;
        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    acc_d    = '0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    count_d  = '0;
                    if (op_b == '0) begin
                        result_d = '0;
                    end
                end
            end
            c_RUN: begin
                if (!flush) begin
                    acc_d    = w_acc_next;
                    mcand_d  = mcand_q << 1;
                    mplier_d = w_mplier_shift;
                    count_d  = count_q + CNT_W'(1);
                    if (w_last) begin
                        result_d = w_acc_next;
                    end
                end
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    // Output logic
    always_comb begin
        alu_ctrl = pipe_ctrl;
        alu_a    = pipe_a;
        alu_b    = pipe_b;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            c_RUN: begin
                alu_ctrl = ADD_CODE;
                alu_a    = acc_q;
                alu_b    = mcand_q;
                busy     = 1'b1;
            end
            c_DONE: begin
                busy = 1'b1;
                done = !flush;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
// ============================================================================
// Module   : tb_alu_mul_sequencer
// Brief    : Randomized self-checking bench for alu_mul_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mul_sequencer;

    localparam int         W        = 64;
    localparam logic [3:0] ADD_CODE = 4'b0010;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         flush;
    logic [3:0]   pipe_ctrl;
    logic [W-1:0] pipe_a;
    logic [W-1:0] pipe_b;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_y;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_errors = 0;
    bit rand_pipe = 1'b0;

    always #5 clk = ~clk;

    // Environment ALU: combinational, a few operations.
    always_comb begin
        case (alu_ctrl)
            4'b0010: alu_y = alu_a + alu_b;
            4'b0110: alu_y = alu_a - alu_b;
            4'b0000: alu_y = alu_a & alu_b;
            4'b0001: alu_y = alu_a | alu_b;
            default: alu_y = alu_a ^ alu_b;
        endcase
    end

    alu_mul_sequencer #(.WIDTH(W), .CNT_W(7), .ADD_CODE(ADD_CODE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .pipe_ctrl (pipe_ctrl),
        .pipe_a    (pipe_a),
        .pipe_b    (pipe_b),
        .alu_ctrl  (alu_ctrl),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycles from accept edge to done: 1 for zero multiplier, else 1 + (msb index + 1).
    function automatic int exp_latency(input logic [W-1:0] b);
        int hi;
        hi = -1;
        for (int i = 0; i < W; i++) begin
            if (b[i]) hi = i;
        end
        return (hi < 0) ? 1 : hi + 2;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (rand_pipe) begin
                pipe_ctrl = 4'($urandom);
                pipe_a    = {$urandom, $urandom};
                pipe_b    = {$urandom, $urandom};
            end
        end
    end

    task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit noisy);
        logic [W-1:0] prod;
        int n;
        int lat;
        prod = a * b;
        lat  = exp_latency(b);
        @(negedge clk);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin
            check("run_busy", W'(busy), W'(1));
            check("run_ctrl", W'(alu_ctrl), W'(ADD_CODE));
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                op_a  = {$urandom, $urandom};
                op_b  = {$urandom, $urandom};
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check("latency", W'(n), W'(lat));
        check("result", result, prod);
        check("done_busy", W'(busy), W'(1));
        check("done_passthru", W'(alu_ctrl), W'(pipe_ctrl));
        @(posedge clk);
        #1;
        check("post_busy", W'(busy), W'(0));
        check("post_done", W'(done), W'(0));
        check("post_hold", result, prod);
    endtask

    initial begin
        logic [W-1:0] prev;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n     = 1'b0;
        start     = 1'b0;
        flush     = 1'b0;
        op_a      = '0;
        op_b      = '0;
        pipe_ctrl = 4'b0110;
        pipe_a    = W'(9);
        pipe_b    = W'(4);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_result", result, W'(0));
        check("idle_ctrl", W'(alu_ctrl), W'(4'b0110));
        check("idle_a", alu_a, W'(9));
        check("idle_b", alu_b, W'(4));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle2_a", alu_a, W'(9));

        rand_pipe = 1'b1;
        mul(W'(3), W'(5), 1'b0);
        mul(W'(64'h1234), W'(0), 1'b0);
        mul({W{1'b1}}, {W{1'b1}}, 1'b0);
        mul(W'(7), W'(64'h8000_0000_0000_0000), 1'b0);

        // Flush during the second RUN cycle.
        prev = result;
        @(negedge clk);
        start = 1'b1; op_a = W'(5); op_b = W'(6);
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; flush = 1'b1;
        check("flush_run_done", W'(done), W'(0));
        @(posedge clk); #1; flush = 1'b0;
        check("flush_busy", W'(busy), W'(0));
        check("flush_done", W'(done), W'(0));
        check("flush_result", result, prev);
        mul(W'(6), W'(7), 1'b0);

        // Flush in DONE suppresses the pulse.
        @(negedge clk);
        start = 1'b1; op_a = W'(1); op_b = W'(0);
        @(posedge clk); #1; start = 1'b0;
        check("zero_done", W'(done), W'(1));
        flush = 1'b1;
        #1;
        check("flush_done_pulse", W'(done), W'(0));
        @(posedge clk); #1; flush = 1'b0;
        check("flush_done_idle", W'(busy), W'(0));

        // start together with flush in IDLE is ignored.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op_a = W'(3); op_b = W'(3);
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        check("start_flush_ign", W'(busy), W'(0));

        // Asynchronous reset mid-RUN.
        @(negedge clk);
        start = 1'b1; op_a = W'(5); op_b = W'(8'hFF);
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", W'(busy), W'(0));
        check("arst_done", W'(done), W'(0));
        check("arst_result", result, W'(0));
        check("arst_passthru", alu_a, pipe_a);
        @(negedge clk);
        rst_n = 1'b1;
        mul(W'(10), W'(10), 1'b1);

        for (int i = 0; i < 30; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rb = rb >> $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) rb = '0;
            mul(ra, rb, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
